sync_fifo_flags: RTL and testbench

//  Parametrised single-clock FIFO: successor to the team's basic passenger/luggage FIFO.
//  - Uses all DEPTH entries; DEPTH need not be a power of two.
//  - Adds an occupancy count, programmable almost-full/almost-empty flags,
//    a synchronous flush, a read-valid strobe and sticky overflow/underflow errors.
//  - Buffers between producer and consumer stages wherever back-pressure status is needed.

---
 rtl/sync_fifo_flags.sv | 87 ++++++++
 tb/tb_sync_fifo_flags.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO using all DEPTH entries (any DEPTH >= 2), with occupancy count,
// programmable almost flags, synchronous flush, read-valid strobe and sticky error flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         wr_enable,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         rd_enable,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Explicit wrap so non-power-of-two depths use exactly DEPTH entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  assign wr_ok = wr_enable & ~full;
  assign rd_ok = rd_enable & ~empty;

  always_ff @(posedge clk) begin
    if (reset_n && !clear && wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      // Flush drops any access this cycle; data_out keeps its last value.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_enable && full)  overflow  <= 1'b1;
      if (rd_enable && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a 16-deep and a 5-deep instance checked against a queue model.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear [2];
  logic       wr    [2];
  logic       rd    [2];
  logic [7:0] din   [2];

  logic [7:0] dout [2];
  logic       rv [2], fl [2], em [2], af [2], ae [2], ov [2], un [2];
  logic [4:0] cnt0;
  logic [2:0] cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, flags derived from its size.
  logic [7:0] mq [2][$];
  logic [7:0] mdout [2];
  bit         mrv [2], mov [2], mun [2];
  int         mdepth [2] = '{16, 5};
  int         maf    [2] = '{12, 4};
  int         mae    [2] = '{2, 1};

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut0 (
    .clk(clk), .reset_n(rst_n), .clear(clear[0]), .wr_enable(wr[0]), .data_in(din[0]),
    .rd_enable(rd[0]), .data_out(dout[0]), .rd_valid(rv[0]), .full(fl[0]), .empty(em[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt0), .overflow(ov[0]), .underflow(un[0]));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .clear(clear[1]), .wr_enable(wr[1]), .data_in(din[1]),
    .rd_enable(rd[1]), .data_out(dout[1]), .rd_valid(rv[1]), .full(fl[1]), .empty(em[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt1), .overflow(ov[1]), .underflow(un[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset(int i);
    mq[i].delete();
    mdout[i] = 8'h00;
    mrv[i] = 0; mov[i] = 0; mun[i] = 0;
  endfunction

  function automatic void model_edge(int i);
    int sz;
    bit mfull, mempty;
    sz = mq[i].size();
    mfull = (sz == mdepth[i]);
    mempty = (sz == 0);
    if (!rst_n) model_reset(i);
    else if (clear[i]) begin
      mq[i].delete();
      mrv[i] = 0; mov[i] = 0; mun[i] = 0;
    end else begin
      if (wr[i] && mfull) mov[i] = 1;
      if (rd[i] && mempty) mun[i] = 1;
      mrv[i] = 0;
      if (rd[i] && !mempty) begin
        mdout[i] = mq[i].pop_front();
        mrv[i] = 1;
      end
      if (wr[i] && !mfull) mq[i].push_back(din[i]);
    end
  endfunction

  task automatic check_all(int i);
    int sz;
    logic [31:0] c;
    string p;
    sz = mq[i].size();
    c = (i == 0) ? 32'(cnt0) : 32'(cnt1);
    p = $sformatf("u%0d_", i);
    check({p, "count"},     c,                32'(sz));
    check({p, "full"},      32'(fl[i]),       32'(sz == mdepth[i]));
    check({p, "empty"},     32'(em[i]),       32'(sz == 0));
    check({p, "alm_full"},  32'(af[i]),       32'(sz >= maf[i]));
    check({p, "alm_empty"}, 32'(ae[i]),       32'(sz <= mae[i]));
    check({p, "overflow"},  32'(ov[i]),       32'(mov[i]));
    check({p, "underflow"}, 32'(un[i]),       32'(mun[i]));
    check({p, "rd_valid"},  32'(rv[i]),       32'(mrv[i]));
    check({p, "data_out"},  32'(dout[i]),     32'(mdout[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      clear[i] = 0; wr[i] = 0; rd[i] = 0; din[i] = 8'h00;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    model_reset(0);
    model_reset(1);
    #2;
    check_all(0);
    check_all(1);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill 16 with 0x01..0x10, then drain in order.
    for (int k = 1; k <= 16; k++) begin
      wr[0] = 1; din[0] = 8'(k);
      tick();
      check("u0_af_at_write", 32'(af[0]), 32'(k >= 12));
    end
    wr[0] = 0;
    check("u0_full_after_16", 32'(fl[0]), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      rd[0] = 1;
      tick();
      check("u0_drain_order", 32'(dout[0]), 32'(k));
    end
    rd[0] = 0;
    tick();

    // Refill, then write+read on a full FIFO with 0xAA.
    for (int k = 0; k < 16; k++) begin
      wr[0] = 1; din[0] = 8'($urandom_range(0, 8'hA9));
      tick();
    end
    wr[0] = 1; rd[0] = 1; din[0] = 8'hAA;
    tick();
    check("u0_ovf_cnt", 32'(cnt0), 32'd15);
    wr[0] = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("u0_no_aa", 32'(dout[0] == 8'hAA), 32'd0);
    end
    rd[0] = 0;

    // Wrap-around on the 5-deep instance.
    for (int k = 0; k < 3; k++) begin wr[1] = 1; din[1] = 8'($urandom); tick(); end
    wr[1] = 0;
    for (int k = 0; k < 3; k++) begin rd[1] = 1; tick(); end
    rd[1] = 0;
    for (int k = 0; k < 4; k++) begin wr[1] = 1; din[1] = 8'(8'h21 + k); tick(); end
    wr[1] = 0;
    for (int k = 0; k < 4; k++) begin
      rd[1] = 1;
      tick();
      check("u1_wrap_data", 32'(dout[1]), 32'(8'h21 + k));
    end
    rd[1] = 0;
    tick();
    check("u1_wrap_empty", 32'(cnt1), 32'd0);

    // Underflow on empty, then clear.
    rd[0] = 1;
    tick();
    check("u0_underflow", 32'(un[0]), 32'd1);
    rd[0] = 0; clear[0] = 1;
    tick();
    clear[0] = 0;
    check("u0_unf_cleared", 32'(un[0]), 32'd0);

    // Count 7, clear with a write pending.
    for (int k = 0; k < 7; k++) begin wr[0] = 1; din[0] = 8'($urandom); tick(); end
    clear[0] = 1;
    tick();
    clear[0] = 0; wr[0] = 0;
    check("u0_clear_cnt", 32'(cnt0), 32'd0);

    // Asynchronous reset mid-burst.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 2; i++) begin
        wr[i] = 1; din[i] = 8'($urandom);
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_all(0);
    check_all(1);
    tick();
    rst_n = 1'b1;
    idle_all();
    tick();

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        wr[i]    = ($urandom_range(0, 99) < ((k / 50) % 2 == 0 ? 70 : 30));
        rd[i]    = ($urandom_range(0, 99) < ((k / 50) % 2 == 0 ? 30 : 70));
        din[i]   = 8'($urandom);
        clear[i] = ($urandom_range(0, 63) == 0);
      end
      tick();
    end
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
